// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes and FSM states.
package data_mem_responder_pkg;

   localparam logic MODE_BYTE = 1'b0;
   localparam logic MODE_HALF = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_ACCESS = 3'd2,
      S_MERGE  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/data_mem_responder_byte_lane.sv
// Big-endian lane selection shared by the load and store paths:
// extracts and sign-extends a byte/half from a word, and builds the
// word with only the addressed lane replaced by the store data.
module byte_lane_unit
   import data_mem_responder_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic        mode,
   input  logic [15:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
      logic signed [31:0] r;
      r = b;
      return r;
   endfunction

   function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
      logic signed [31:0] r;
      r = h;
      return r;
   endfunction

   logic [4:0] byte_sh;
   logic [4:0] half_sh;

   // Offset 0 is the most significant lane, so the bit position is (3-offset)*8.
   always_comb begin
      byte_sh    = {~offset, 3'b000};
      half_sh    = {~offset[1], 4'b0000};
      load_val   = '0;
      store_word = word;
      if (mode == MODE_HALF) begin
         load_val                 = sext16(word[half_sh +: 16]);
         store_word[half_sh +: 16] = wdata;
      end else begin
         load_val                = sext8(word[byte_sh +: 8]);
         store_word[byte_sh +: 8] = wdata[7:0];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves byte/half loads and read-modify-write stores
// against an internal word RAM, with programmable wait states and a
// request-hold / ready-pulse handshake.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(WAIT_STATES + 2);

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     cnt;
   logic [AW+1:0]     addr_q;
   logic [15:0]       wdata_q;
   logic              mode_q;
   logic              write_q;
   logic [31:0]       hold;
   logic [31:0]       ram [DEPTH_WORDS];
   logic [AW-1:0]     idx;
   logic              accept;
   logic              req_err;
   logic [31:0]       lane_word;
   logic [31:0]       load_val;
   logic [31:0]       store_word;
   logic              unused_bits;

   // Upper address bits wrap away; only the low half of the store data is ever stored.
   assign unused_bits = ^{addr[31:AW+2], wdata[31:16]};

   assign idx       = addr_q[AW+1:2];
   assign lane_word = (state == S_MERGE) ? hold : ram[idx];

   assign req_err = (state == S_IDLE) &&
                    ((mem_read && mem_write) ||
                     ((mem_read ^ mem_write) && (mode == MODE_HALF) && addr[0]));
   assign accept  = (state == S_IDLE) && (mem_read ^ mem_write) &&
                    !((mode == MODE_HALF) && addr[0]);

   byte_lane_unit u_lane (
      .word       (lane_word),
      .offset     (addr_q[1:0]),
      .mode       (mode_q),
      .wdata      (wdata_q),
      .load_val   (load_val),
      .store_word (store_word)
   );

   // State register; reset returns to IDLE from any state.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (req_err)     state_nxt = S_DONE;
            else if (accept) state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
         end
         S_WAIT:   if (cnt == CW'(1)) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = write_q ? S_MERGE : S_DONE;
         S_MERGE:  state_nxt = S_DONE;
         S_DONE: begin
            ready     = 1'b1;
            state_nxt = S_IDLE;
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Wait counter, error flag and load result.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         if (accept)               cnt <= CW'(WAIT_STATES);
         else if (state == S_WAIT) cnt <= cnt - CW'(1);
         if (state == S_IDLE)      err <= req_err;
         else if (state == S_DONE) err <= 1'b0;
         if (req_err)                              rdata <= '0;
         else if (state == S_ACCESS && !write_q)   rdata <= load_val;
      end
   end

   // Request latch at acceptance and holding word captured in ACCESS.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= addr[AW+1:0];
         wdata_q <= wdata[15:0];
         mode_q  <= mode;
         write_q <= mem_write;
      end
      if (state == S_ACCESS) hold <= ram[idx];
   end

   // RAM write-back of the merged word; a reset during MERGE suppresses it.
   always_ff @(posedge clk) begin
      if (state == S_MERGE && !rst) ram[idx] <= store_word;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (WAIT_STATES=2 and WAIT_STATES=0 builds).
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, mode;
   logic [31:0] addr, wdata, rdata;
   logic        ready, busy, err;
   logic        mem_read0, mem_write0, mode0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        ready0, busy0, err0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mode(mode), .addr(addr), .wdata(wdata), .rdata(rdata),
      .ready(ready), .busy(busy), .err(err)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .mem_read(mem_read0), .mem_write(mem_write0),
      .mode(mode0), .addr(addr0), .wdata(wdata0), .rdata(rdata0),
      .ready(ready0), .busy(busy0), .err(err0)
   );

   // One transaction on dut: lat = number of negedges after the accepting edge until ready.
   task automatic run_acc(input logic rd, input logic wr, input logic md,
                          input logic [31:0] a, input logic [31:0] wd, input bit scramble,
                          output logic [31:0] r, output logic e, output int lat);
      @(negedge clk);
      mem_read = rd; mem_write = wr; mode = md; addr = a; wdata = wd;
      @(posedge clk);
      lat = 0;
      r = '0; e = 1'b0;
      if (scramble) begin
         #1;
         addr = a ^ 32'h3; wdata = ~wd; mode = ~md;
      end
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (ready) break;
      end
      if (!ready) begin
         vectors++; miscompares++;
         $display("FAIL timeout addr=%h: no ready within %0d cycles", a, lat);
      end
      r = rdata; e = err;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      mem_read = 0; mem_write = 0; mode = 0; addr = 0; wdata = 0;
      mem_read0 = 0; mem_write0 = 0; mode0 = 0; addr0 = 0; wdata0 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
      vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      rst = 1'b0;
   endtask

   task automatic test_half;
      logic [31:0] r; logic e; int lat;
      run_acc(1'b0, 1'b1, 1'b1, 32'h10, 32'h0000BEEF, 1'b0, r, e, lat);
      vectors++; if (lat !== 5) begin miscompares++; $display("FAIL sh_latency got=%0d exp=5", lat); end
      vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL sh_err got=%b exp=0", e); end
      run_acc(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, r, e, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL lh_latency got=%0d exp=4", lat); end
      vectors++; if (r !== 32'hFFFFBEEF) begin miscompares++; $display("FAIL lh_10 got=%h exp=ffffbeef", r); end
   endtask

   task automatic test_bytes;
      logic [31:0] r; logic e; int lat;
      logic [7:0]  bv [4];
      logic [31:0] ev [4];
      bv = '{8'h11, 8'h22, 8'h83, 8'h44};
      ev = '{32'h00000011, 32'h00000022, 32'hFFFFFF83, 32'h00000044};
      for (int i = 0; i < 4; i++)
         run_acc(1'b0, 1'b1, 1'b0, 32'h20 + i, {24'hABCDEF, bv[i]}, 1'b0, r, e, lat);
      for (int i = 0; i < 4; i++) begin
         run_acc(1'b1, 1'b0, 1'b0, 32'h20 + i, 32'h0, 1'b0, r, e, lat);
         vectors++; if (r !== ev[i]) begin miscompares++; $display("FAIL lb_%0d got=%h exp=%h", i, r, ev[i]); end
      end
      run_acc(1'b1, 1'b0, 1'b1, 32'h22, 32'h0, 1'b0, r, e, lat);
      vectors++; if (r !== 32'hFFFF8344) begin miscompares++; $display("FAIL lh_22 got=%h exp=ffff8344", r); end
      run_acc(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, r, e, lat);
      vectors++; if (r !== 32'h00001122) begin miscompares++; $display("FAIL lh_20 got=%h exp=00001122", r); end
   endtask

   task automatic test_merge;
      logic [31:0] r; logic e; int lat;
      run_acc(1'b0, 1'b1, 1'b1, 32'h40, 32'h0000AABB, 1'b0, r, e, lat);
      run_acc(1'b0, 1'b1, 1'b1, 32'h42, 32'h0000CCDD, 1'b0, r, e, lat);
      run_acc(1'b0, 1'b1, 1'b0, 32'h41, 32'h0000007F, 1'b0, r, e, lat);
      run_acc(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, r, e, lat);
      vectors++; if (r !== 32'hFFFFAA7F) begin miscompares++; $display("FAIL merge_hi got=%h exp=ffffaa7f", r); end
      run_acc(1'b1, 1'b0, 1'b1, 32'h42, 32'h0, 1'b0, r, e, lat);
      vectors++; if (r !== 32'hFFFFCCDD) begin miscompares++; $display("FAIL merge_lo got=%h exp=ffffccdd", r); end
      run_acc(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, r, e, lat);
      vectors++; if (r !== 32'hFFFFFFAA) begin miscompares++; $display("FAIL merge_b0 got=%h exp=ffffffaa", r); end
   endtask

   task automatic test_errors;
      logic [31:0] r; logic e; int lat;
      run_acc(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 1'b0, r, e, lat);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL misalign_latency got=%0d exp=1", lat); end
      vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL misalign_err got=%b exp=1", e); end
      vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL misalign_rdata got=%h exp=0", r); end
      run_acc(1'b1, 1'b1, 1'b0, 32'h20, 32'h000000FF, 1'b0, r, e, lat);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL conflict_latency got=%0d exp=1", lat); end
      vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL conflict_err got=%b exp=1", e); end
      run_acc(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, r, e, lat);
      vectors++; if (r !== 32'h00000011) begin miscompares++; $display("FAIL conflict_ram got=%h exp=00000011", r); end
      vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL err_clears got=%b exp=0", e); end
   endtask

   task automatic test_reset_merge;
      logic [31:0] r; logic e; int lat;
      run_acc(1'b0, 1'b1, 1'b1, 32'h30, 32'h00001234, 1'b0, r, e, lat);
      run_acc(1'b0, 1'b1, 1'b1, 32'h32, 32'h00005678, 1'b0, r, e, lat);
      @(negedge clk);
      mem_write = 1'b1; mode = 1'b0; addr = 32'h30; wdata = 32'h55;
      @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_write = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL merge_busy got=%b exp=1", busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
      vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b exp=0", ready); end
      run_acc(1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 1'b0, r, e, lat);
      vectors++; if (r !== 32'h00001234) begin miscompares++; $display("FAIL rst_nowrite got=%h exp=00001234", r); end
   endtask

   task automatic test_wrap_latch;
      logic [31:0] r; logic e; int lat;
      run_acc(1'b0, 1'b1, 1'b1, 32'h400, 32'h00001234, 1'b0, r, e, lat);
      run_acc(1'b1, 1'b0, 1'b1, 32'h000, 32'h0, 1'b0, r, e, lat);
      vectors++; if (r !== 32'h00001234) begin miscompares++; $display("FAIL wrap got=%h exp=00001234", r); end
      run_acc(1'b1, 1'b0, 1'b0, 32'h23, 32'h0, 1'b1, r, e, lat);
      vectors++; if (r !== 32'h00000044) begin miscompares++; $display("FAIL latched got=%h exp=00000044", r); end
   endtask

   task automatic test_hold;
      logic [31:0] r; logic e; int lat;
      run_acc(1'b1, 1'b0, 1'b0, 32'h21, 32'h0, 1'b0, r, e, lat);
      mem_read = 1'b1; addr = 32'h21;
      @(negedge clk);
      mem_read = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL no_reaccept got=%b exp=0", busy); end
   endtask

   task automatic test_zero_wait;
      int lat;
      @(negedge clk);
      mem_write0 = 1'b1; mode0 = 1'b0; addr0 = 32'h5; wdata0 = 32'h83;
      @(posedge clk);
      lat = 0;
      while (lat < 20) begin @(negedge clk); lat++; if (ready0) break; end
      mem_write0 = 1'b0;
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL ws0_store_latency got=%0d exp=3", lat); end
      @(negedge clk);
      mem_read0 = 1'b1; addr0 = 32'h5;
      @(posedge clk);
      lat = 0;
      while (lat < 20) begin @(negedge clk); lat++; if (ready0) break; end
      mem_read0 = 1'b0;
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL ws0_load_latency got=%0d exp=2", lat); end
      vectors++; if (rdata0 !== 32'hFFFFFF83) begin miscompares++; $display("FAIL ws0_lb got=%h exp=ffffff83", rdata0); end
   endtask

   initial begin
      test_reset;
      test_half;
      test_bytes;
      test_merge;
      test_errors;
      test_reset_merge;
      test_wrap_latch;
      test_hold;
      test_zero_wait;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
